// File: rtl/alu_sequencer.sv
// alu_sequencer: runs a W-bit operation (W = 8*BYTES) through an external
// 8-bit ALU one byte per cycle, least significant byte first, chaining the
// carry between passes.
//
// Optional feature: define ALU_SEQ_FLAGS_EN to keep a flags register loaded
// from rsp_status on every response handshake. With it, req_use_flag_carry
// selects flags[0] as the byte-0 carry. Without it, flags is tied to 0 and
// req_use_flag_carry is ignored.
//
// Ports
//   clk, reset            : single clock, async active-high reset
//   req_valid/req_ready   : request handshake
//   req_a, req_b          : W-bit operands
//   req_lut, req_enable_a : ALU function code / active-low A enable (passed through)
//   req_carry_in          : carry into byte 0
//   req_use_flag_carry    : use stored carry flag as byte-0 carry
//   alu_a, alu_b, alu_lut, alu_enable_a, alu_carry_in : drive the 8-bit ALU
//   alu_q, alu_status     : ALU result / {ovf, neg, zero, carry}
//   rsp_valid/rsp_ready   : response handshake
//   rsp_q, rsp_status     : W-bit result / {ovf, neg, all-bytes-zero, carry}
//   flags                 : last handshaken rsp_status (feature build only)
//
// State table
//   IDLE | ready for a request, ALU inputs parked
//   RUN  | one ALU pass per cycle, byte index idx
//   DONE | response held until rsp_ready
module alu_sequencer #(
  parameter int BYTES = 2,
  localparam int W = 8 * BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [3:0]   req_lut,
  input  logic         req_enable_a,
  input  logic         req_carry_in,
  input  logic         req_use_flag_carry,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [3:0]   alu_lut,
  output logic         alu_enable_a,
  output logic         alu_carry_in,
  input  logic [7:0]   alu_q,
  input  logic [3:0]   alu_status,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_q,
  output logic [3:0]   rsp_status,
  output logic [3:0]   flags
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

  state_t      state, next_state;
  logic [1:0]  idx;
  logic [W-1:0] a_q, b_q;
  logic [3:0]  lut_q;
  logic        ena_q;
  logic        cin0_q;
  logic        carry_q;
  logic        zero_q;
  logic        zero_now;
  logic        cin_sel;

`ifdef ALU_SEQ_FLAGS_EN
  assign cin_sel = req_use_flag_carry ? flags[0] : req_carry_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (state == DONE && rsp_ready) begin
      flags <= rsp_status;
    end
  end
`else
  logic unused_use_flag_carry;
  assign unused_use_flag_carry = req_use_flag_carry;
  assign cin_sel = req_carry_in;
  assign flags   = '0;
`endif

  // Zero is only true for the whole word if every byte pass reported zero.
  assign zero_now = alu_status[1] & ((idx == 2'd0) ? 1'b1 : zero_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_lut      = '0;
    alu_enable_a = 1'b1;
    alu_carry_in = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = RUN;
      end
      RUN: begin
        alu_a        = a_q[8*idx +: 8];
        alu_b        = b_q[8*idx +: 8];
        alu_lut      = lut_q;
        alu_enable_a = ena_q;
        alu_carry_in = (idx == 2'd0) ? cin0_q : carry_q;
        if (idx == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      lut_q      <= '0;
      ena_q      <= 1'b1;
      cin0_q     <= 1'b0;
      idx        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      rsp_q      <= '0;
      rsp_status <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q    <= req_a;
            b_q    <= req_b;
            lut_q  <= req_lut;
            ena_q  <= req_enable_a;
            cin0_q <= cin_sel;
            idx    <= '0;
          end
        end
        RUN: begin
          rsp_q[8*idx +: 8] <= alu_q;
          carry_q <= alu_status[0];
          zero_q  <= zero_now;
          idx     <= idx + 2'd1;
          if (idx == LAST_IDX) begin
            rsp_status <= {alu_status[3], alu_status[2], zero_now, alu_status[0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL provide parameter BYTES, default 2, the number of 8-bit ALU passes per operation (legal 1..4); operand width W = 8*BYTES.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, operation request present.
REQ-005 SHALL have port req_ready, output, 1, sequencer can accept a request.
REQ-006 SHALL have ports req_a and req_b, input, W, operands.
REQ-007 SHALL have port req_lut, input, 4, ALU function code passed unchanged to the ALU.
REQ-008 SHALL have port req_enable_a, input, 1, active-low A-operand enable passed to the ALU.
REQ-009 SHALL have port req_carry_in, input, 1, carry into byte 0.
REQ-010 SHALL have port req_use_flag_carry, input, 1, select stored carry flag as the byte-0 carry.
REQ-011 SHALL have ports alu_a and alu_b, output, 8; alu_lut, output, 4; alu_enable_a, output, 1; alu_carry_in, output, 1; these drive the 8-bit ALU.
REQ-012 SHALL have ports alu_q, input, 8, and alu_status, input, 4, from the ALU (status[0]=carry out, [1]=zero, [2]=negative, [3]=overflow).
REQ-013 SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_q, output, W; rsp_status, output, 4; flags, output, 4.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL assert req_ready only in IDLE; on req_valid&&req_ready it SHALL latch all req_* inputs, clear byte index to 0 and enter RUN.
REQ-016 In RUN it SHALL drive alu_a/alu_b with byte[idx] of the latched operands, alu_lut/alu_enable_a from the latched request, and alu_carry_in = byte-0 carry when idx=0, otherwise the carry captured from the previous byte.
REQ-017 Each RUN cycle it SHALL capture alu_q into rsp_q byte[idx] and alu_status[0] as the chained carry, then increment idx.
REQ-018 After byte BYTES-1 it SHALL enter DONE; rsp_valid SHALL rise exactly BYTES cycles after the accept edge.
REQ-019 rsp_status SHALL be {final overflow, final negative, AND of all byte zero bits, final carry}.
REQ-020 In DONE, rsp_valid, rsp_q and rsp_status SHALL hold stable until rsp_valid&&rsp_ready, then return to IDLE; the next accept is no earlier than the following cycle.
REQ-021 Outside RUN it SHALL drive alu_a=0, alu_b=0, alu_lut=0, alu_enable_a=1 and alu_carry_in=0.
REQ-022 req_valid outside IDLE SHALL be ignored with no side effect.

Reset
REQ-023 reset SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_q=0, rsp_status=0, flags=0 and ALU outputs to REQ-021 values.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no response ever issued for it.

Configuration
REQ-025 With macro ALU_SEQ_FLAGS_EN defined, flags SHALL register rsp_status on every response handshake, and req_use_flag_carry=1 SHALL select flags[0] instead of req_carry_in as byte-0 carry.
REQ-026 Without ALU_SEQ_FLAGS_EN, flags SHALL be constant 0, req_use_flag_carry SHALL be ignored, and ports SHALL be identical.

Verification (bench uses a behavioural adder model of the ALU, BYTES=2)
REQ-027 Add 0x00FF+0x0001, cin=0 -> alu_carry_in=1 on byte 1, rsp_q=0x0100, rsp_status carry=0, zero=0, rsp_valid 2 cycles after accept.
REQ-028 Add 0xFFFF+0x0001 -> rsp_q=0x0000, carry=1, zero=1.
REQ-029 Hold rsp_ready low 5 cycles in DONE -> rsp_valid/rsp_q/rsp_status stable, req_ready=0, pulsed req_valid ignored.
REQ-030 Assert reset in RUN after byte 0 -> outputs at reset values immediately, no rsp_valid afterwards.
REQ-031 With ALU_SEQ_FLAGS_EN: 0xFFFF+0x0001 then 0x0000+0x0000 with req_use_flag_carry=1 -> second rsp_q=0x0001; without macro -> 0x0000 and flags=0.
